// File: rtl/piso_frame_ctrl.sv
// piso_frame_ctrl: sequences a parallel-load / serial-shift register.
// Accepts a WIDTH-bit word over valid/ready, shifts it out MSB-first with
// s_valid/s_last framing, then forces GAP_CYCLES idle cycles before the
// next word can be taken.
//
// Handshake: a word transfers on a rising edge where in_valid=1 and
// in_ready=1. in_ready is high only in IDLE with clear low. The producer
// must hold the word until that edge, and p_in is sampled only then.
module piso_frame_ctrl #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] p_in,
  output logic             in_ready,
  input  logic             hold,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_last,
  output logic             busy,
  output logic [7:0]       frame_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  // Terminal value of the gap counter; unused when GAP_CYCLES is 0.
  localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]   bit_cnt;
  logic [3:0]      gap_cnt;
  logic            accept;
  logic            shift_en;
  logic            frame_done;
  logic            gap_done;

  // Next-state and per-edge control strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    gap_done   = 1'b0;
    case (state)
      IDLE: begin
        // hold does not block acceptance; it only freezes shifting.
        if (in_valid) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (!hold) begin
          if (bit_cnt == '0) begin
            frame_done = 1'b1;
            if (GAP_CYCLES == 0) state_next = IDLE;
            else                 state_next = GAP;
          end else begin
            shift_en = 1'b1;
          end
        end
      end
      GAP: begin
        // hold is deliberately ignored here.
        if (gap_cnt == GAP_LAST) begin
          gap_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; clear aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  // Shift register and bit counter: load on accept, shift MSB-first.
  always_ff @(posedge clk) begin
    if (clear) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (accept) begin
      shift_reg <= p_in;
      bit_cnt   <= BIT_LAST;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
      bit_cnt   <= bit_cnt - CW'(1);
    end
  end

  // Gap counter: runs only while in GAP, restarts from zero each frame.
  always_ff @(posedge clk) begin
    if (clear || gap_done || state != GAP) gap_cnt <= '0;
    else                                    gap_cnt <= gap_cnt + 4'd1;
  end

  // Completed-frame counter, wraps modulo 256.
  always_ff @(posedge clk) begin
    if (clear)           frame_cnt <= '0;
    else if (frame_done) frame_cnt <= frame_cnt + 8'd1;
  end

  assign in_ready = (state == IDLE) && !clear;
  assign s_valid  = (state == SHIFT);
  assign s_out    = (state == SHIFT) ? shift_reg[WIDTH-1] : 1'b0;
  assign s_last   = (state == SHIFT) && (bit_cnt == '0);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_piso_frame_ctrl.sv
// Bench for piso_frame_ctrl: directed steps then randomized traffic,
// checked against a frame-level model (a queue of pending serial bits,
// a remaining-gap count and a completed-frame count).
module tb_piso_frame_ctrl;

  localparam int W     = 4;
  localparam int GAP_A = 1;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=4, GAP_CYCLES=1
  logic         clear, in_valid, hold;
  logic [W-1:0] p_in;
  logic         in_ready, s_out, s_valid, s_last, busy;
  logic [7:0]   frame_cnt;

  // Instance B: WIDTH=4, GAP_CYCLES=0
  logic         clear_b, in_valid_b, hold_b;
  logic [W-1:0] p_in_b;
  logic         in_ready_b, s_out_b, s_valid_b, s_last_b, busy_b;
  logic [7:0]   frame_cnt_b;

  piso_frame_ctrl #(.WIDTH(W), .GAP_CYCLES(GAP_A)) dut_a (
    .clk(clk), .clear(clear), .in_valid(in_valid), .p_in(p_in),
    .in_ready(in_ready), .hold(hold), .s_out(s_out), .s_valid(s_valid),
    .s_last(s_last), .busy(busy), .frame_cnt(frame_cnt)
  );

  piso_frame_ctrl #(.WIDTH(W), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .clear(clear_b), .in_valid(in_valid_b), .p_in(p_in_b),
    .in_ready(in_ready_b), .hold(hold_b), .s_out(s_out_b), .s_valid(s_valid_b),
    .s_last(s_last_b), .busy(busy_b), .frame_cnt(frame_cnt_b)
  );

  // Scoreboard state
  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];
  logic exp_qb[$];
  int   gap_left = 0;
  int   frames   = 0;
  int   frames_b = 0;
  int   valid_cycles = 0;
  int   idle_cycles_b = 0;
  bit   last_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare instance A outputs with the model after an edge.
  task automatic sample_a();
    logic ev;
    ev = (exp_q.size() > 0);
    check("a_s_valid", {31'd0, s_valid}, {31'd0, ev});
    check("a_s_out", {31'd0, s_out}, {31'd0, ev ? exp_q[0] : 1'b0});
    check("a_s_last", {31'd0, s_last}, {31'd0, ev && exp_q.size() == 1});
    check("a_busy", {31'd0, busy}, {31'd0, ev || gap_left > 0});
    check("a_in_ready", {31'd0, in_ready}, {31'd0, !clear && !ev && gap_left == 0});
    check("a_frame_cnt", {24'd0, frame_cnt}, frames % 256);
    if (s_valid) valid_cycles++;
    if (s_last) last_seen = 1'b1;
  endtask

  // Driver: one clock for instance A, model advanced for the same edge.
  task automatic tick_a(input logic v, input logic [W-1:0] d, input logic h);
    logic dummy;
    clear = 1'b0; in_valid = v; p_in = d; hold = h;
    if (exp_q.size() > 0) begin
      if (!h) begin
        dummy = exp_q.pop_front();
        if (exp_q.size() == 0) begin
          frames++;
          gap_left = GAP_A;
        end
      end
    end else if (gap_left > 0) begin
      gap_left--;
    end else if (v) begin
      for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
    end
    @(posedge clk); #1;
    sample_a();
  endtask

  task automatic clear_a(input logic v, input logic [W-1:0] d);
    clear = 1'b1; in_valid = v; p_in = d; hold = 1'b0;
    exp_q.delete();
    gap_left = 0;
    frames = 0;
    @(posedge clk); #1;
    sample_a();
  endtask

  // Driver for instance B: producer always valid, never holds.
  task automatic tick_b(input logic [W-1:0] d);
    logic dummy;
    logic ev;
    clear_b = 1'b0; in_valid_b = 1'b1; p_in_b = d; hold_b = 1'b0;
    if (exp_qb.size() > 0) begin
      dummy = exp_qb.pop_front();
      if (exp_qb.size() == 0) frames_b++;
    end else begin
      for (int i = W - 1; i >= 0; i--) exp_qb.push_back(d[i]);
    end
    @(posedge clk); #1;
    ev = (exp_qb.size() > 0);
    check("b_s_valid", {31'd0, s_valid_b}, {31'd0, ev});
    check("b_s_out", {31'd0, s_out_b}, {31'd0, ev ? exp_qb[0] : 1'b0});
    check("b_s_last", {31'd0, s_last_b}, {31'd0, ev && exp_qb.size() == 1});
    check("b_busy", {31'd0, busy_b}, {31'd0, ev});
    check("b_in_ready", {31'd0, in_ready_b}, {31'd0, !ev});
    check("b_frame_cnt", {24'd0, frame_cnt_b}, frames_b % 256);
    if (!s_valid_b) idle_cycles_b++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] seq;
    logic [W-1:0] lastpat;

    clear = 1'b1; in_valid = 1'b0; p_in = '0; hold = 1'b0;
    clear_b = 1'b1; in_valid_b = 1'b0; p_in_b = '0; hold_b = 1'b0;

    // 1. Reset with a word offered: nothing accepted, ready low during clear.
    clear_a(1'b1, 4'hF);
    clear_a(1'b1, 4'hF);
    check("rst_frame_cnt", {24'd0, frame_cnt}, 0);
    clear = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_ready_after_clear", {31'd0, in_ready}, 1);

    // 2. Basic frame 1011.
    tick_a(1'b1, 4'b1011, 1'b0);
    seq = {3'b000, s_out}; lastpat = {3'b000, s_last};
    for (int k = 0; k < 3; k++) begin
      tick_a(1'b0, '0, 1'b0);
      seq = {seq[W-2:0], s_out}; lastpat = {lastpat[W-2:0], s_last};
    end
    check("basic_bits", {28'd0, seq}, 32'b1011);
    check("basic_last", {28'd0, lastpat}, 32'b0001);
    tick_a(1'b0, '0, 1'b0);
    check("basic_gap_valid", {31'd0, s_valid}, 0);
    check("basic_gap_busy", {31'd0, busy}, 1);
    tick_a(1'b0, '0, 1'b0);
    check("basic_ready", {31'd0, in_ready}, 1);
    check("basic_frames", {24'd0, frame_cnt}, 1);

    // 3. Hold for 3 cycles while the 0 bit is on s_out.
    valid_cycles = 0;
    tick_a(1'b1, 4'b1011, 1'b0);
    tick_a(1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick_a(1'b0, '0, 1'b1);
      check("hold_bit", {31'd0, s_out}, 0);
    end
    for (int k = 0; k < 4; k++) tick_a(1'b0, '0, 1'b0);
    check("hold_frame_len", valid_cycles, 7);
    check("hold_frames", {24'd0, frame_cnt}, 2);

    // 4. Back-pressure: producer offers words mid-frame, changes p_in.
    tick_a(1'b1, 4'b1011, 1'b0);
    tick_a(1'b1, 4'b0110, 1'b0);
    tick_a(1'b1, 4'b0110, 1'b0);
    tick_a(1'b1, 4'b1111, 1'b0);
    tick_a(1'b1, 4'b0110, 1'b0);
    tick_a(1'b1, 4'b0110, 1'b0);
    tick_a(1'b1, 4'b0110, 1'b0);
    seq = {3'b000, s_out};
    for (int k = 0; k < 3; k++) begin
      tick_a(1'b0, '0, 1'b0);
      seq = {seq[W-2:0], s_out};
    end
    check("bp_second_word", {28'd0, seq}, 32'b0110);
    tick_a(1'b0, '0, 1'b0);
    tick_a(1'b0, '0, 1'b0);
    check("bp_frames", {24'd0, frame_cnt}, 4);

    // 5. Abort with clear while the third bit is on s_out.
    last_seen = 1'b0;
    tick_a(1'b1, 4'b1011, 1'b0);
    tick_a(1'b0, '0, 1'b0);
    tick_a(1'b0, '0, 1'b0);
    check("abort_third_bit", {31'd0, s_out}, 1);
    clear_a(1'b0, '0);
    check("abort_valid", {31'd0, s_valid}, 0);
    check("abort_frame_cnt", {24'd0, frame_cnt}, 0);
    check("abort_no_last", {31'd0, last_seen}, 0);
    clear = 1'b0;
    #1;
    check("abort_ready", {31'd0, in_ready}, 1);

    // Randomized traffic with random hold.
    for (int n = 0; n < 400; n++)
      tick_a(1'($urandom_range(0, 1)), W'($urandom_range(0, 15)),
             1'($urandom_range(0, 3) == 0));
    for (int n = 0; n < 10; n++) tick_a(1'b0, '0, 1'b0);

    // 6. GAP_CYCLES=0: 256 back-to-back frames, wrap to zero.
    clear_b = 1'b1; in_valid_b = 1'b1;
    @(posedge clk); #1;
    idle_cycles_b = 0;
    for (int n = 0; n < 256 * (W + 1); n++) tick_b(W'($urandom_range(0, 15)));
    check("wrap_frame_cnt", {24'd0, frame_cnt_b}, 0);
    check("wrap_idle_cycles", idle_cycles_b, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
